// File: rtl/data_route_pkg.sv
// Shared types and constants for the stream_route_xbar crossbar slice.
package data_route_pkg;

  localparam int CNT_W = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Select field must encode 0 (disabled) plus one code per input.
  function automatic int sel_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/route_out_slice.sv
// One crossbar output: registered beat, valid flag and accept term.
// Optional accepted-beat counter is built only with ROUTE_BEAT_CNT_EN.
module route_out_slice
  import data_route_pkg::*;
#(
  parameter int W = 1536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [W-1:0]     i_data,
  input  logic             i_ready,
`ifdef ROUTE_BEAT_CNT_EN
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
`endif
  output logic [W-1:0]     o_data,
  output logic             o_valid,
  output logic             o_acc
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // i_load is only raised while o_acc is high, so a stalled beat is never overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_acc   = !r_valid || i_ready;

`ifdef ROUTE_BEAT_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (r_valid && i_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/stream_route_xbar.sv
// AXI-Stream crossbar: N_IN inputs routed to N_OUT registered outputs with broadcast.
// Define ROUTE_BEAT_CNT_EN to add the per-output beat_cnt port and counters.
module stream_route_xbar
  import data_route_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int N_OUT = 8,
  parameter int W     = 1536,
  parameter int SEL_W = sel_width(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_OUT*SEL_W-1:0] ctrl,
  input  logic                   ctrl_load,
  output logic                   ctrl_busy,
  input  logic [N_IN*W-1:0]      s_tdata,
  input  logic [N_IN-1:0]        s_tvalid,
  output logic [N_IN-1:0]        s_tready,
  output logic [N_OUT*W-1:0]     m_tdata,
  output logic [N_OUT-1:0]       m_tvalid,
`ifdef ROUTE_BEAT_CNT_EN
  output logic [N_OUT*CNT_W-1:0] beat_cnt,
`endif
  input  logic [N_OUT-1:0]       m_tready
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [SEL_W-1:0]            r_sel [N_OUT];
  logic [N_IN-1:0][N_OUT-1:0]  w_dest;
  logic [N_OUT-1:0]            w_acc;
  logic [N_IN-1:0]             w_fire;
  logic [N_OUT-1:0]            w_load;
  logic [W-1:0]                w_odata [N_OUT];
  logic                        w_latch;

  // Codes above N_IN match no input, so such an output simply has no source.
  always_comb begin
    w_dest = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (r_sel[j] == SEL_W'(i + 1)) w_dest[i][j] = 1'b1;
      end
    end
  end

  // Broadcast is all-or-nothing: every destination must be able to accept.
  always_comb begin
    s_tready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      s_tready[i] = (r_state == RUN) && (|w_dest[i]) && ((w_dest[i] & ~w_acc) == '0);
    end
  end

  assign w_fire = s_tvalid & s_tready;

  always_comb begin
    w_load = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      w_odata[j] = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (w_dest[i][j]) begin
          w_odata[j] = s_tdata[i*W +: W];
          w_load[j]  = w_fire[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      for (int unsigned j = 0; j < N_OUT; j++) r_sel[j] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        for (int unsigned j = 0; j < N_OUT; j++) r_sel[j] <= ctrl[j*SEL_W +: SEL_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    ctrl_busy   = 1'b0;
    case (r_state)
      RUN: begin
        if (ctrl_load) begin
          ctrl_busy = 1'b1;
          if (m_tvalid == '0 && w_fire == '0) w_latch = 1'b1;
          else                                w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        ctrl_busy = 1'b1;
        if (m_tvalid == '0) begin
          w_latch     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    route_out_slice #(
      .W(W)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[j]),
      .i_data  (w_odata[j]),
      .i_ready (m_tready[j]),
`ifdef ROUTE_BEAT_CNT_EN
      .i_clr   (w_latch),
      .o_cnt   (beat_cnt[j*CNT_W +: CNT_W]),
`endif
      .o_data  (m_tdata[j*W +: W]),
      .o_valid (m_tvalid[j]),
      .o_acc   (w_acc[j])
    );
  end

endmodule

// File: tb/tb_stream_route_xbar.sv
// Self-checking bench for stream_route_xbar (N_IN=5, N_OUT=8, W=128).
module tb_stream_route_xbar;

  localparam int N_IN  = 5;
  localparam int N_OUT = 8;
  localparam int W     = 128;
  localparam int SEL_W = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_OUT*SEL_W-1:0] ctrl;
  logic                   ctrl_load;
  logic                   ctrl_busy;
  logic [N_IN*W-1:0]      s_tdata;
  logic [N_IN-1:0]        s_tvalid;
  logic [N_IN-1:0]        s_tready;
  logic [N_OUT*W-1:0]     m_tdata;
  logic [N_OUT-1:0]       m_tvalid;
  logic [N_OUT-1:0]       m_tready;
`ifdef ROUTE_BEAT_CNT_EN
  logic [N_OUT*32-1:0]    beat_cnt;
`endif

  stream_route_xbar #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .ctrl_load(ctrl_load), .ctrl_busy(ctrl_busy),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid),
`ifdef ROUTE_BEAT_CNT_EN
    .beat_cnt(beat_cnt),
`endif
    .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: routing table, per-output held beat, drain flag.
  int              msel  [N_OUT];
  logic [N_OUT-1:0] mv;
  logic [W-1:0]    md    [N_OUT];
  bit              mdrain;
  logic [31:0]     mcnt  [N_OUT];
  logic [N_IN-1:0] mfire;
  logic [W-1:0]    outq  [N_OUT][$];

  typedef struct {
    logic [N_IN-1:0]  vld;
    logic [7:0]       t0, t1;
    logic [N_OUT-1:0] rdy;
    logic [N_IN-1:0]  e_rdy;
    logic [N_OUT-1:0] e_v;
    logic [7:0]       e_d0, e_d1;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [N_OUT*SEL_W-1:0] mkc(input int s0, s1, s2, s3, s4, s5, s6, s7);
    int s [N_OUT];
    logic [N_OUT*SEL_W-1:0] c;
    s = '{s0, s1, s2, s3, s4, s5, s6, s7};
    c = '0;
    for (int j = 0; j < N_OUT; j++) c[j*SEL_W +: SEL_W] = SEL_W'(s[j]);
    return c;
  endfunction

  task automatic model_reset();
    mdrain = 1'b0;
    mv     = '0;
    mfire  = '0;
    for (int j = 0; j < N_OUT; j++) begin
      msel[j] = 0; md[j] = '0; mcnt[j] = '0;
    end
  endtask

  // Check the current cycle against the model, then advance both across one edge.
  task automatic cyc();
    logic [N_OUT-1:0] acc, nv;
    logic [N_IN-1:0]  erdy, fire;
    logic             ebusy, latch, has, ok;
    logic [W-1:0]     nd [N_OUT];
    #1;
    for (int j = 0; j < N_OUT; j++) acc[j] = !mv[j] || m_tready[j];
    for (int i = 0; i < N_IN; i++) begin
      has = 1'b0; ok = 1'b1;
      for (int j = 0; j < N_OUT; j++)
        if (msel[j] == i + 1) begin has = 1'b1; if (!acc[j]) ok = 1'b0; end
      erdy[i] = !mdrain && has && ok;
    end
    fire  = s_tvalid & erdy;
    ebusy = mdrain || ctrl_load;
    chk("s_tready", W'(s_tready), W'(erdy));
    chk("m_tvalid", W'(m_tvalid), W'(mv));
    chk("ctrl_busy", W'(ctrl_busy), W'(ebusy));
    for (int j = 0; j < N_OUT; j++) chk($sformatf("m_tdata%0d", j), m_tdata[j*W +: W], md[j]);
`ifdef ROUTE_BEAT_CNT_EN
    for (int j = 0; j < N_OUT; j++) chk($sformatf("beat_cnt%0d", j), W'(beat_cnt[j*32 +: 32]), W'(mcnt[j]));
`endif
    for (int j = 0; j < N_OUT; j++)
      if (rst_n && m_tvalid[j] && m_tready[j]) outq[j].push_back(m_tdata[j*W +: W]);

    latch = 1'b0;
    if (!mdrain) begin
      if (ctrl_load) begin
        if (mv == '0 && fire == '0) latch = 1'b1;
        else                        mdrain = 1'b1;
      end
    end else if (mv == '0) begin
      latch = 1'b1; mdrain = 1'b0;
    end
    for (int j = 0; j < N_OUT; j++) begin
      nv[j] = mv[j] && !m_tready[j];
      nd[j] = md[j];
      for (int i = 0; i < N_IN; i++)
        if (fire[i] && msel[j] == i + 1) begin nv[j] = 1'b1; nd[j] = s_tdata[i*W +: W]; end
      if (latch)                     mcnt[j] = '0;
      else if (mv[j] && m_tready[j]) mcnt[j] = mcnt[j] + 32'd1;
    end
    mv = nv;
    for (int j = 0; j < N_OUT; j++) begin
      md[j] = nd[j];
      if (latch) msel[j] = int'(ctrl[j*SEL_W +: SEL_W]);
    end
    mfire = fire;
    if (!rst_n) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ctrl(input logic [N_OUT*SEL_W-1:0] c);
    ctrl = c; ctrl_load = 1'b1;
    cyc();
    ctrl_load = 1'b0;
  endtask

  task automatic check_seq(input int j, input logic [7:0] base, input int n);
    chk($sformatf("out%0d_len", j), W'(outq[j].size()), W'(n));
    for (int k = 0; k < n && k < outq[j].size(); k++)
      chk($sformatf("out%0d_beat%0d", j, k), outq[j][k], rep(base + 8'(k)));
  endtask

  initial begin
    int n0, n3, n2;
    logic [N_OUT*SEL_W-1:0] cfg;

    tbl[0] = '{5'b00001, 8'h11, 8'h00, 8'hFF, 5'b00011, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{5'b00001, 8'h12, 8'h00, 8'hFF, 5'b00011, 8'h01, 8'h11, 8'h00};
    tbl[2] = '{5'b00011, 8'h13, 8'h21, 8'hFF, 5'b00011, 8'h01, 8'h12, 8'h00};
    tbl[3] = '{5'b00000, 8'h00, 8'h00, 8'hFF, 5'b00011, 8'h03, 8'h13, 8'h21};
    tbl[4] = '{5'b00000, 8'h00, 8'h00, 8'hFF, 5'b00011, 8'h00, 8'h13, 8'h21};
    tbl[5] = '{5'b00001, 8'h14, 8'h00, 8'h00, 5'b00011, 8'h00, 8'h13, 8'h21};
    tbl[6] = '{5'b00001, 8'h15, 8'h00, 8'h00, 5'b00010, 8'h01, 8'h14, 8'h21};
    tbl[7] = '{5'b00001, 8'h15, 8'h00, 8'hFF, 5'b00011, 8'h01, 8'h14, 8'h21};
    tbl[8] = '{5'b00000, 8'h00, 8'h00, 8'hFF, 5'b00011, 8'h01, 8'h15, 8'h21};
    tbl[9] = '{5'b00000, 8'h00, 8'h00, 8'hFF, 5'b00011, 8'h00, 8'h15, 8'h21};

    rst_n = 1'b0; ctrl = '0; ctrl_load = 1'b0;
    s_tvalid = '0; s_tdata = '0; m_tready = '1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;

    // 1: disabled routing accepts nothing
    for (int k = 0; k < 10; k++) begin
      s_tvalid = '1;
      for (int i = 0; i < N_IN; i++) s_tdata[i*W +: W] = rep(8'(k + 1));
      #1;
      chk("t1_s_tready", W'(s_tready), '0);
      chk("t1_m_tvalid", W'(m_tvalid), '0);
      cyc();
    end
    s_tvalid = '0;

    // 2: two point-to-point routes
    ctrl = mkc(1, 2, 0, 0, 0, 0, 0, 0); ctrl_load = 1'b1;
    #1;
    chk("t2_busy_load", W'(ctrl_busy), W'(1));
    cyc();
    ctrl_load = 1'b0;
    #1;
    chk("t2_busy_after", W'(ctrl_busy), W'(0));
    for (int k = 0; k < 10; k++) begin
      s_tvalid = tbl[k].vld; m_tready = tbl[k].rdy;
      s_tdata  = '0;
      s_tdata[0 +: W] = rep(tbl[k].t0);
      s_tdata[W +: W] = rep(tbl[k].t1);
      #1;
      chk($sformatf("t2_rdy%0d", k), W'(s_tready), W'(tbl[k].e_rdy));
      chk($sformatf("t2_v%0d", k), W'(m_tvalid), W'(tbl[k].e_v));
      chk($sformatf("t2_d0_%0d", k), m_tdata[0 +: W], rep(tbl[k].e_d0));
      chk($sformatf("t2_d1_%0d", k), m_tdata[W +: W], rep(tbl[k].e_d1));
      cyc();
    end
    s_tvalid = '0; m_tready = '1;

    // 3: broadcast input2 to outputs 2,5,7 with out5 back-pressured
    load_ctrl(mkc(1, 0, 3, 0, 0, 3, 0, 3));
    for (int j = 0; j < N_OUT; j++) outq[j].delete();
    n2 = 0;
    for (int k = 0; k < 12; k++) begin
      s_tvalid = 5'b00100;
      s_tdata[2*W +: W] = rep(8'h31 + 8'(n2));
      m_tready = (k >= 2 && k <= 5) ? 8'b1101_1111 : 8'hFF;
      #1;
      if (k >= 2 && k <= 5) chk("t3_stall", W'(s_tready[2]), W'(0));
      cyc();
      if (mfire[2]) n2++;
    end
    s_tvalid = '0; m_tready = '1;
    repeat (3) cyc();
    check_seq(2, 8'h31, n2);
    check_seq(5, 8'h31, n2);
    check_seq(7, 8'h31, n2);

    // 4: swap out0 from input0 to input3 while traffic is in flight
    for (int j = 0; j < N_OUT; j++) outq[j].delete();
    n0 = 0; n3 = 0;
    cfg = mkc(4, 0, 3, 0, 0, 3, 0, 3);
    for (int k = 0; k < 26; k++) begin
      s_tvalid = 5'b01001;
      s_tdata[0*W +: W] = rep(8'h40 + 8'(n0));
      s_tdata[3*W +: W] = rep(8'h60 + 8'(n3));
      m_tready = {7'h7F, 1'(k % 2)};
      ctrl = cfg; ctrl_load = (k == 6);
      cyc();
      if (mfire[0]) n0++;
      if (mfire[3]) n3++;
    end
    ctrl_load = 1'b0; s_tvalid = '0; m_tready = '1;
    repeat (3) cyc();
    chk("t4_len", W'(outq[0].size()), W'(n0 + n3));
    for (int k = 0; k < n0 + n3 && k < outq[0].size(); k++)
      chk($sformatf("t4_beat%0d", k), outq[0][k],
          (k < n0) ? rep(8'h40 + 8'(k)) : rep(8'h60 + 8'(k - n0)));

    // 5: illegal select, then reset in the middle of a drain
    load_ctrl(mkc(1, 0, 0, 0, 7, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      s_tvalid = '1;
      for (int i = 0; i < N_IN; i++) s_tdata[i*W +: W] = rep(8'h50 + 8'(k));
      #1;
      chk("t5_out4_off", W'(m_tvalid[4]), W'(0));
      cyc();
    end
    s_tvalid = 5'b00001; m_tready = '0;
    s_tdata[0 +: W] = rep(8'h70);
    cyc();
    s_tvalid = '0;
    load_ctrl(mkc(2, 2, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_drain_busy", W'(ctrl_busy), W'(1));
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; m_tready = '1;
    #1;
    chk("t5_rst_valid", W'(m_tvalid), '0);
    chk("t5_rst_busy", W'(ctrl_busy), '0);
    chk("t5_rst_ready", W'(s_tready), '0);
    for (int j = 0; j < N_OUT; j++) chk($sformatf("t5_rst_data%0d", j), m_tdata[j*W +: W], '0);
    cyc();

`ifdef ROUTE_BEAT_CNT_EN
    // 6: beat counter on out3
    load_ctrl(mkc(0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 100; k++) begin
      s_tvalid = 5'b00001;
      s_tdata[0 +: W] = rep(8'(k));
      cyc();
    end
    s_tvalid = '0;
    repeat (2) cyc();
    chk("t6_cnt100", W'(beat_cnt[3*32 +: 32]), W'(100));
    load_ctrl(mkc(0, 0, 0, 1, 0, 0, 0, 0));
    chk("t6_cnt_clr", W'(beat_cnt[3*32 +: 32]), W'(0));
`endif

    // Randomized traffic, reconfiguration and occasional reset
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      ctrl_load = ($urandom_range(0, 29) == 0);
      ctrl      = (N_OUT*SEL_W)'($urandom);
      s_tvalid  = N_IN'($urandom);
      m_tready  = N_OUT'($urandom | $urandom);
      for (int i = 0; i < N_IN; i++) s_tdata[i*W +: W] = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
